freq_calc: RTL and testbench
============================

# freq_calc

Post-processing stage for the equal-precision frequency meter: consumes the `cnt_s` / `cnt_x` / `irq` outputs of the frequency measurement block and computes the frequency in Hz as round(cnt_x × REF_FREQ / cnt_s) with a 64-cycle sequential divider. It also contains a watchdog that pulses `meas_rst` when no measurement completes within a timeout. This recovers the divided range after a sudden drop in input frequency.

## Interface
- `REF_FREQ`, default 100_000_000: standard clock frequency in Hz; multiplier applied to `cnt_x`.
- `TIMEOUT`, default 50_000_000: watchdog period in `clk_100M` cycles (0.5 s). Must be ≥ 2.
- `clk_100M`  in  1  system clock, 100 MHz. This is the only clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `cnt_s`  in  32  standard-clock count of the last gate.
- `cnt_x`  in  32  signal count of the last gate (already ×32 in the divided range).
- `irq`  in  1  level, high while the measurement gate is closed. A rising edge means the counts are valid.
- `freq`  out  32  last computed frequency in Hz.
- `freq_valid`  out  1  one-cycle pulse when `freq` updates.
- `div_err`  out  1  one-cycle pulse when a measurement with cnt_s = 0 is discarded.
- `ovf`  out  1  level; high when the last result saturated.
- `busy`  out  1  high while in MUL or DIV.
- `meas_rst`  out  1  one-cycle watchdog pulse; drives the divided-range meas_rst.
- `timeout`  out  1  sticky level; set by a watchdog expiry, cleared by the next irq rising edge.

## Operation
- Edge detect: `irq_d` registers `irq`. An event is `irq & ~irq_d`. No extra synchronizer is used, because `irq` is already in the `clk_100M` domain.
- FSM states:
  - **IDLE**
    - On an event with cnt_s ≠ 0: latch `cnt_s` into `den_r` and `cnt_x` into `num_r`, then go to MUL.
    - On an event with cnt_s = 0: pulse `div_err` and stay in IDLE.
  - **MUL**
    - Dividend (64-bit) = num_r × REF_FREQ + (den_r >> 1). The half-divisor term gives round-half-up.
    - Clear remainder (33-bit) and quotient (64-bit).
    - Set `it` = 0, then go to DIV.
  - **DIV**
    - Restoring division, 1 quotient bit per cycle, MSB first, 64 iterations.
    - Per iteration: shift remainder left taking the dividend MSB; if rem ≥ den_r, subtract and set quotient bit = 1.
    - After iteration 63, go to DONE.
  - **DONE**
    - If quotient[63:32] ≠ 0: `freq` = 32'hFFFF_FFFF and `ovf` = 1.
    - Otherwise: `freq` = quotient[31:0] and `ovf` = 0.
    - Pulse `freq_valid`, then return to IDLE.
- An event arriving while busy is dropped; counts are not relatched. The watchdog still restarts on that event.
- Watchdog:
  - `wd_cnt` (32-bit) increments every cycle.
  - It clears on any event, including cnt_s = 0 events and events dropped while busy.
  - When wd_cnt = TIMEOUT−1: `meas_rst` = 1 for one cycle, `wd_cnt` clears, and `timeout` is set.
  - If an event and expiry coincide, the event wins: no `meas_rst`, and `timeout` is cleared.
- Width rules:
  - REF_FREQ × 2^32 fits in 64 bits for REF_FREQ < 2^32.
  - The remainder needs 33 bits so the compare does not lose the carry.

## Timing
- Reset values: all outputs 0, `freq` = 0, FSM in IDLE, `irq_d` = 0, `wd_cnt` = 0.
- Event sampled at edge k; the FSM then spends 1 cycle in MUL, 64 cycles in DIV and 1 cycle in DONE, one state per clock edge.
- `freq`, `ovf` and `freq_valid` update on the same edge. `freq_valid` is high for exactly one cycle.
  - Fixed latency: 66 cycles from the event sample edge to `freq_valid`.
- `busy` is high for exactly 65 cycles: edge k+1 through edge k+66.
- `div_err` goes high the cycle after the event sample edge; it is high for exactly one cycle.
- `freq` holds between updates. It does not change on `div_err` or on a watchdog expiry.
- If `irq` is high out of reset, there is no event until it falls and rises again.
- Reset asserted mid-division: state is abandoned, no `freq_valid`, and outputs return to their reset values asynchronously.
- Minimum event spacing for no drops is 67 cycles. The real gate is ≥ CNT_THRESH cycles.

## Test plan
- cnt_s = 10_000_000, cnt_x = 1_000_000, irq 0→1 → `freq` = 10_000_000, `freq_valid` 66 cycles after the sample edge, `ovf` = 0, `busy` high for 65 cycles.
- cnt_s = 3, cnt_x = 1 → `freq` = 33_333_333. Then cnt_s = 3, cnt_x = 2 → `freq` = 66_666_667 (rounding).
- cnt_s = 1, cnt_x = 100 → quotient 1e10 → `freq` = 32'hFFFF_FFFF, `ovf` = 1. The next valid measurement clears `ovf`.
- cnt_s = 0 with an irq edge → `div_err` one-cycle pulse, no `freq_valid`, `freq` unchanged, watchdog restarted.
- TIMEOUT = 100, irq held low:
  - `meas_rst` pulses at cycles 100, 200, …; `timeout` = 1.
  - An irq edge on the cycle wd_cnt = 99 → no pulse, `timeout` clears.
- Second irq edge 10 cycles after the first → dropped; the result equals the first measurement. `rst_n` low at DIV iteration 30 → no `freq_valid`, and all outputs read 0.

Source files
------------

// File: rtl/freq_calc.sv
// freq_calc
//   Post-processing stage for the equal-precision frequency meter. On each
//   rising edge of irq it latches cnt_s / cnt_x and computes
//   freq = round(cnt_x * REF_FREQ / cnt_s) with a 64-cycle restoring divider.
//   A watchdog pulses meas_rst when no measurement completes within TIMEOUT
//   cycles, restarting the measurement block after a sudden frequency drop.
//
// Ports
//   clk_100M   in   system clock (only clock)
//   rst_n      in   asynchronous active-low reset
//   cnt_s      in   [31:0] standard-clock count of the last gate
//   cnt_x      in   [31:0] signal count of the last gate
//   irq        in   level, high while the gate is closed; rising edge = counts valid
//   freq       out  [31:0] last computed frequency in Hz (saturates)
//   freq_valid out  one-cycle pulse when freq updates
//   div_err    out  one-cycle pulse when a cnt_s = 0 measurement is discarded
//   ovf        out  high when the last result saturated
//   busy       out  high while multiplying / dividing
//   meas_rst   out  one-cycle watchdog pulse
//   timeout    out  sticky watchdog flag, cleared by the next irq event
module freq_calc #(
    parameter logic [31:0] REF_FREQ = 32'd100_000_000,
    parameter logic [31:0] TIMEOUT  = 32'd50_000_000
) (
    input  logic        clk_100M,
    input  logic        rst_n,
    input  logic [31:0] cnt_s,
    input  logic [31:0] cnt_x,
    input  logic        irq,
    output logic [31:0] freq,
    output logic        freq_valid,
    output logic        div_err,
    output logic        ovf,
    output logic        busy,
    output logic        meas_rst,
    output logic        timeout
);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } state_t;

    state_t      state;
    logic        irq_d;
    logic        irq_seen;
    logic        ev;
    logic [31:0] num_r;
    logic [31:0] den_r;
    logic [63:0] dvd;
    logic [63:0] quo;
    logic [32:0] rem;
    logic [32:0] rem_sh;
    logic        rem_ge;
    logic [5:0]  it;
    logic [31:0] wd_cnt;

    // irq_seen blocks the first edge after reset: irq_d has not yet sampled
    // a real low level, so a high irq out of reset must not count as an edge.
    assign ev = irq & ~irq_d & irq_seen;

    // Remainder is kept 33 bits wide so the shifted value never loses its carry.
    assign rem_sh = (rem << 1) | {32'd0, dvd[63]};
    assign rem_ge = (rem_sh >= {1'b0, den_r});

    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            irq_d    <= 1'b0;
            irq_seen <= 1'b0;
        end else begin
            irq_d    <= irq;
            irq_seen <= 1'b1;
        end
    end

    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            num_r      <= '0;
            den_r      <= '0;
            dvd        <= '0;
            quo        <= '0;
            rem        <= '0;
            it         <= '0;
            freq       <= '0;
            freq_valid <= 1'b0;
            div_err    <= 1'b0;
            ovf        <= 1'b0;
            busy       <= 1'b0;
        end else begin
            freq_valid <= 1'b0;
            div_err    <= 1'b0;
            // busy trails the state by one edge: high from edge k+1 to k+66
            busy       <= (state == MUL) || (state == DIV);
            case (state)
                IDLE: begin
                    if (ev) begin
                        if (cnt_s == '0) begin
                            div_err <= 1'b1;
                        end else begin
                            den_r <= cnt_s;
                            num_r <= cnt_x;
                            state <= MUL;
                        end
                    end
                end
                MUL: begin
                    // Adding half the divisor turns the truncating divide into round-half-up.
                    dvd   <= ({32'd0, num_r} * {32'd0, REF_FREQ}) + {33'd0, den_r[31:1]};
                    rem   <= '0;
                    quo   <= '0;
                    it    <= '0;
                    state <= DIV;
                end
                DIV: begin
                    rem   <= rem_ge ? (rem_sh - {1'b0, den_r}) : rem_sh;
                    quo   <= {quo[62:0], rem_ge};
                    dvd   <= dvd << 1;
                    it    <= it + 6'd1;
                    if (it == 6'd63) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (|quo[63:32]) begin
                        freq <= '1;
                        ovf  <= 1'b1;
                    end else begin
                        freq <= quo[31:0];
                        ovf  <= 1'b0;
                    end
                    freq_valid <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Any event restarts the watchdog, even discarded or dropped ones; an
    // event coinciding with expiry wins.
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt   <= '0;
            meas_rst <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            meas_rst <= 1'b0;
            if (ev) begin
                wd_cnt  <= '0;
                timeout <= 1'b0;
            end else if (wd_cnt == TIMEOUT - 32'd1) begin
                wd_cnt   <= '0;
                meas_rst <= 1'b1;
                timeout  <= 1'b1;
            end else begin
                wd_cnt <= wd_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_freq_calc.sv
// tb_freq_calc
//   Directed bench for freq_calc (REF_FREQ default, TIMEOUT = 100).
module tb_freq_calc;

    logic        clk_100M = 1'b0;
    logic        rst_n;
    logic [31:0] cnt_s;
    logic [31:0] cnt_x;
    logic        irq;
    logic [31:0] freq;
    logic        freq_valid;
    logic        div_err;
    logic        ovf;
    logic        busy;
    logic        meas_rst;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    freq_calc #(
        .REF_FREQ(32'd100_000_000),
        .TIMEOUT (32'd100)
    ) dut (
        .clk_100M  (clk_100M),
        .rst_n     (rst_n),
        .cnt_s     (cnt_s),
        .cnt_x     (cnt_x),
        .irq       (irq),
        .freq      (freq),
        .freq_valid(freq_valid),
        .div_err   (div_err),
        .ovf       (ovf),
        .busy      (busy),
        .meas_rst  (meas_rst),
        .timeout   (timeout)
    );

    always #5 clk_100M = ~clk_100M;

    task automatic tick();
        @(posedge clk_100M);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full measurement: event sampled at the first edge, then 66 edges.
    task automatic measure(input logic [31:0] s, input logic [31:0] x,
                           input logic [31:0] exp_f, input logic exp_ovf, input string tag);
        int nb = 0;
        int fv_at = 0;
        int fv_n = 0;
        cnt_s = s;
        cnt_x = x;
        irq   = 1'b1;
        tick();
        chk({tag, "_busy_k"}, busy, 1'b0);
        for (int j = 1; j <= 66; j++) begin
            tick();
            if (j == 1) irq = 1'b0;
            if (busy) nb++;
            if (freq_valid) begin
                fv_n++;
                if (fv_at == 0) fv_at = j;
            end
        end
        chk({tag, "_lat"}, fv_at, 66);
        chk({tag, "_fvn"}, fv_n, 1);
        chk({tag, "_busyn"}, nb, 65);
        chk({tag, "_freq"}, freq, exp_f);
        chk({tag, "_ovf"}, ovf, exp_ovf);
        chk({tag, "_busy_end"}, busy, 1'b0);
        tick();
        chk({tag, "_fv_drop"}, freq_valid, 1'b0);
    endtask

    initial begin
        int p1;
        int p2;
        int np;
        int nfv;
        int nbusy;
        logic [31:0] f_hold;

        // Reset with irq already high: no event may follow release.
        rst_n = 1'b0;
        irq   = 1'b1;
        cnt_s = 32'd5;
        cnt_x = 32'd5;
        #1;
        chk("rst_freq", freq, 32'd0);
        chk("rst_outs", {freq_valid, div_err, ovf, busy, meas_rst, timeout}, 6'd0);
        tick();
        tick();
        rst_n = 1'b1;
        nbusy = 0;
        for (int j = 0; j < 5; j++) begin
            tick();
            if (busy) nbusy++;
        end
        chk("irq_high_oor", nbusy, 0);
        irq = 1'b0;
        tick();
        tick();

        measure(32'd10_000_000, 32'd1_000_000, 32'd10_000_000, 1'b0, "m10M");
        measure(32'd3, 32'd1, 32'd33_333_333, 1'b0, "m3_1");
        measure(32'd3, 32'd2, 32'd66_666_667, 1'b0, "m3_2");
        measure(32'd1, 32'd100, 32'hFFFF_FFFF, 1'b1, "movf");
        measure(32'd10_000_000, 32'd1_000_000, 32'd10_000_000, 1'b0, "movf_clr");
        measure(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd100_000_000, 1'b0, "mwide");

        // cnt_s = 0 event, then let the watchdog run with irq low.
        f_hold = freq;
        cnt_s  = 32'd0;
        cnt_x  = 32'd7;
        irq    = 1'b1;
        tick();
        chk("derr_pulse", div_err, 1'b1);
        chk("derr_timeout_clr", timeout, 1'b0);
        p1 = 0;
        p2 = 0;
        np = 0;
        nfv = 0;
        for (int j = 1; j <= 299; j++) begin
            tick();
            if (j == 1) begin
                chk("derr_width", div_err, 1'b0);
                irq = 1'b0;
            end
            if (freq_valid) nfv++;
            if (meas_rst) begin
                np++;
                if (p1 == 0) p1 = j;
                else if (p2 == 0) p2 = j;
            end
        end
        chk("derr_no_fv", nfv, 0);
        chk("derr_freq_hold", freq, f_hold);
        chk("wd_first", p1, 100);
        chk("wd_second", p2, 200);
        chk("wd_count", np, 2);
        chk("wd_timeout_set", timeout, 1'b1);
        // Event lands exactly on the expiry edge.
        irq = 1'b1;
        tick();
        chk("wd_coinc_no_pulse", meas_rst, 1'b0);
        chk("wd_coinc_timeout", timeout, 1'b0);
        chk("wd_coinc_derr", div_err, 1'b1);
        irq = 1'b0;
        tick();
        tick();

        // Second event 10 cycles after the first is dropped.
        cnt_s = 32'd3;
        cnt_x = 32'd1;
        irq   = 1'b1;
        tick();
        nfv = 0;
        for (int j = 1; j <= 70; j++) begin
            tick();
            if (j == 1) irq = 1'b0;
            if (j == 9) begin
                cnt_s = 32'd1;
                cnt_x = 32'd100;
                irq   = 1'b1;
            end
            if (j == 12) irq = 1'b0;
            if (freq_valid) nfv++;
        end
        chk("drop_fvn", nfv, 1);
        chk("drop_freq", freq, 32'd33_333_333);
        chk("drop_ovf", ovf, 1'b0);

        // Reset in the middle of the division.
        measure(32'd10_000_000, 32'd1_000_000, 32'd10_000_000, 1'b0, "pre_abort");
        cnt_s = 32'd3;
        cnt_x = 32'd2;
        irq   = 1'b1;
        tick();
        for (int j = 1; j <= 31; j++) begin
            tick();
            if (j == 1) irq = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk("abort_freq", freq, 32'd0);
        chk("abort_outs", {freq_valid, div_err, ovf, busy, meas_rst, timeout}, 6'd0);
        tick();
        rst_n = 1'b1;
        nfv = 0;
        nbusy = 0;
        for (int j = 0; j < 70; j++) begin
            tick();
            if (freq_valid) nfv++;
            if (busy) nbusy++;
        end
        chk("abort_no_fv", nfv, 0);
        chk("abort_no_busy", nbusy, 0);
        chk("abort_freq_kept", freq, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
